// File: rtl/adc_if_pkg.sv
// Shared definitions for the DRDY/24-bit ADC frame interface.
// Used by the frame emitter and by the timing hub that consumes the frames.
package adc_if_pkg;

  // Data bits per frame; this is also the frame word width.
  localparam int unsigned READ_DCLKS     = 24;
  localparam int unsigned FRAME_W        = READ_DCLKS;

  // frame_idx counts modulo this value.
  localparam int unsigned FRAMES_PER_PWM = 8;
  localparam int unsigned FRAME_IDX_W    = 3;

  typedef enum logic {
    ST_SETTLE = 1'b0,
    ST_RUN    = 1'b1
  } adc_state_e;

endpackage

// File: rtl/toggle_sync_rx.sv
// Toggle-to-pulse receiver: 2FF synchroniser for a toggle from another
// clock domain, followed by an edge detector that produces a 1-clock pulse
// for every toggle.
module toggle_sync_rx (
  input  logic clk_i,
  input  logic rst_i,
  input  logic tog_i,
  output logic pulse_o
);

  (* ASYNC_REG = "TRUE" *) logic meta_q;
  (* ASYNC_REG = "TRUE" *) logic sync_q;
  logic                          last_q;

  // Two synchronising stages plus one stage of history for edge detection.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
      last_q <= 1'b0;
    end else begin
      meta_q <= tog_i;
      sync_q <= meta_q;
      last_q <= sync_q;
    end
  end

  assign pulse_o = sync_q ^ last_q;

endmodule

// File: rtl/adc_frame_emitter.sv
// ADC-side frame transmitter (dclk domain). Each sample period raises drdy
// for one dclk, then shifts a 24-bit word out MSB-first. A synchronised
// sync_tog edge restarts the period and suppresses drdy while settling.
// Optional build macro: ADC_TEST_RAMP_EN (adds ramp_mode test-pattern input).
module adc_frame_emitter
  import adc_if_pkg::*;
#(
  parameter int unsigned TS_DCLKS  = 128,
  parameter int unsigned SETTLE_TS = 7
) (
  input  logic                   dclk,
  input  logic                   rst_dclk,
  input  logic                   sync_tog,
  input  logic [FRAME_W-1:0]     sample_in,
  input  logic                   sample_valid,
`ifdef ADC_TEST_RAMP_EN
  input  logic                   ramp_mode,
`endif
  output logic                   drdy,
  output logic                   dout,
  output logic [FRAME_IDX_W-1:0] frame_idx,
  output logic                   settling,
  output logic                   underrun,
  output logic                   overrun
);

  localparam int unsigned PC_W  = $clog2(TS_DCLKS);
  localparam int unsigned SET_W = $clog2(SETTLE_TS + 1);

  localparam logic [PC_W-1:0]        PC_LAST     = PC_W'(TS_DCLKS - 1);
  localparam logic [PC_W-1:0]        PC_READ     = PC_W'(READ_DCLKS);
  localparam logic [SET_W-1:0]       SETTLE_LAST = SET_W'(SETTLE_TS - 1);
  localparam logic [FRAME_IDX_W-1:0] IDX_LAST    = FRAME_IDX_W'(FRAMES_PER_PWM - 1);

  adc_state_e               state_q, state_d;
  logic [PC_W-1:0]          pc_q, pc_d;
  logic [SET_W-1:0]         settle_q, settle_d;
  logic [FRAME_W-1:0]       hold_q, hold_d;
  logic                     hold_full_q, hold_full_d;
  logic [FRAME_W-1:0]       shift_q, shift_d;
  logic [FRAME_IDX_W-1:0]   idx_q, idx_d;
  logic                     settling_q, settling_d;
  logic                     underrun_q, underrun_d;
  logic                     overrun_q, overrun_d;
  logic                     drdy_q, drdy_d;
  logic                     dout_q, dout_d;
  logic                     sync_pulse;
  logic                     consume;
  logic                     ramp_sel;
`ifdef ADC_TEST_RAMP_EN
  logic [FRAME_W-1:0]       ramp_q, ramp_d;
  assign ramp_sel = ramp_mode;
`else
  assign ramp_sel = 1'b0;
`endif

  toggle_sync_rx u_sync (
    .clk_i   (dclk),
    .rst_i   (rst_dclk),
    .tog_i   (sync_tog),
    .pulse_o (sync_pulse)
  );

  assign consume = (state_q == ST_RUN) && (pc_q == '0);

  // Next-state: period schedule, holding register, sticky flags, sync abort.
  always_comb begin
    state_d     = state_q;
    pc_d        = (pc_q == PC_LAST) ? '0 : pc_q + PC_W'(1);
    settle_d    = settle_q;
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
    shift_d     = shift_q;
    idx_d       = idx_q;
    settling_d  = settling_q;
    underrun_d  = underrun_q;
    overrun_d   = overrun_q;
`ifdef ADC_TEST_RAMP_EN
    ramp_d      = ramp_q;
`endif

    case (state_q)
      // The leave condition is evaluated in the last dclk of the final
      // settle period, so the first drdy lands exactly SETTLE_TS periods
      // after reset/sync.
      ST_SETTLE: begin
        if (pc_q == PC_LAST) begin
          if (settle_q == SETTLE_LAST) begin
            state_d    = ST_RUN;
            settling_d = 1'b0;
          end else begin
            settle_d = settle_q + SET_W'(1);
          end
        end
      end
      ST_RUN: begin
        if (pc_q == '0) begin
          if (ramp_sel) begin
`ifdef ADC_TEST_RAMP_EN
            shift_d = ramp_q;
`endif
          end else begin
            shift_d     = hold_q;
            hold_full_d = 1'b0;
            if (!hold_full_q) underrun_d = 1'b1;
          end
        end else if (pc_q <= PC_READ) begin
          shift_d = {shift_q[FRAME_W-2:0], 1'b0};
          if (pc_q == PC_READ) begin
            idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + FRAME_IDX_W'(1);
`ifdef ADC_TEST_RAMP_EN
            if (ramp_sel) ramp_d = ramp_q + FRAME_W'(1);
`endif
          end
        end
      end
      default: state_d = ST_SETTLE;
    endcase

    // A load in the consume cycle replaces the word just taken, so the
    // register stays full and it is not an overrun.
    if (sample_valid) begin
      hold_d      = sample_in;
      hold_full_d = 1'b1;
      if (hold_full_q && !consume) overrun_d = 1'b1;
    end

    if (sync_pulse) begin
      state_d    = ST_SETTLE;
      pc_d       = '0;
      settle_d   = '0;
      settling_d = 1'b1;
      idx_d      = '0;
      underrun_d = 1'b0;
      overrun_d  = 1'b0;
`ifdef ADC_TEST_RAMP_EN
      ramp_d     = '0;
`endif
    end

    // Outputs are registered from the next state so they change only on
    // the rising edge and are glitch-free at the receiver.
    drdy_d = (state_d == ST_RUN) && (pc_d == '0);
    dout_d = ((state_d == ST_RUN) && (pc_d != '0) && (pc_d <= PC_READ))
             ? shift_d[FRAME_W-1] : 1'b0;
  end

  // State registers with asynchronous reset.
  always_ff @(posedge dclk or posedge rst_dclk) begin
    if (rst_dclk) begin
      state_q     <= ST_SETTLE;
      pc_q        <= '0;
      settle_q    <= '0;
      hold_q      <= '0;
      hold_full_q <= 1'b0;
      shift_q     <= '0;
      idx_q       <= '0;
      settling_q  <= 1'b1;
      underrun_q  <= 1'b0;
      overrun_q   <= 1'b0;
      drdy_q      <= 1'b0;
      dout_q      <= 1'b0;
`ifdef ADC_TEST_RAMP_EN
      ramp_q      <= '0;
`endif
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      settle_q    <= settle_d;
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
      shift_q     <= shift_d;
      idx_q       <= idx_d;
      settling_q  <= settling_d;
      underrun_q  <= underrun_d;
      overrun_q   <= overrun_d;
      drdy_q      <= drdy_d;
      dout_q      <= dout_d;
`ifdef ADC_TEST_RAMP_EN
      ramp_q      <= ramp_d;
`endif
    end
  end

  assign drdy      = drdy_q;
  assign dout      = dout_q;
  assign frame_idx = idx_q;
  assign settling  = settling_q;
  assign underrun  = underrun_q;
  assign overrun   = overrun_q;

endmodule

// File: tb/tb_adc_frame_emitter.sv
// Scoreboard bench for adc_frame_emitter: stimulus pushes expected frames
// (drdy cycle, word, frame_idx); a negedge monitor pops and compares.
module tb_adc_frame_emitter;

  logic        dclk;
  logic        rst_dclk;
  logic        sync_tog;
  logic [23:0] sample_in;
  logic        sample_valid;
  logic        drdy;
  logic        dout;
  logic [2:0]  frame_idx;
  logic        settling;
  logic        underrun;
  logic        overrun;

  adc_frame_emitter #(.TS_DCLKS(128), .SETTLE_TS(7)) dut (
    .dclk         (dclk),
    .rst_dclk     (rst_dclk),
    .sync_tog     (sync_tog),
    .sample_in    (sample_in),
    .sample_valid (sample_valid),
`ifdef ADC_TEST_RAMP_EN
    .ramp_mode    (1'b0),
`endif
    .drdy         (drdy),
    .dout         (dout),
    .frame_idx    (frame_idx),
    .settling     (settling),
    .underrun     (underrun),
    .overrun      (overrun)
  );

  typedef struct {
    int unsigned cyc;
    logic [23:0] word;
    logic [2:0]  idx;
  } frame_t;

  frame_t      exp_q[$];
  int unsigned cyc;
  int unsigned tests;
  int unsigned fails;
  logic        quiet;

  initial dclk = 1'b0;
  always #5 dclk = ~dclk;

  always @(posedge dclk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s @cyc %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  // Advance to #1 after posedge number n.
  task automatic go_to(input int unsigned n);
    while (cyc < n) begin
      @(posedge dclk);
      #1;
    end
  endtask

  task automatic load(input logic [23:0] w);
    sample_in    = w;
    sample_valid = 1'b1;
    @(posedge dclk);
    #1;
    sample_valid = 1'b0;
  endtask

  // Monitor: frame capture on drdy, then frame_idx check one dclk after the last bit.
  int unsigned cap_cnt;
  logic [23:0] cap_word;
  logic        idx_pending;
  frame_t      cur;

  always @(negedge dclk) begin
    if (quiet) begin
      cap_cnt     = 0;
      idx_pending = 1'b0;
    end else if (cap_cnt > 0) begin
      cap_word = {cap_word[22:0], dout};
      cap_cnt--;
      if (cap_cnt == 0) begin
        chk("frame_word", {8'h0, cap_word}, {8'h0, cur.word});
        idx_pending = 1'b1;
      end
    end else begin
      if (idx_pending) begin
        chk("frame_idx", {29'h0, frame_idx}, {29'h0, cur.idx});
        idx_pending = 1'b0;
      end
      chk("idle_dout", {31'h0, dout}, 32'h0);
      if (drdy) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_drdy_cyc", cyc, 32'hFFFF_FFFF);
        end else begin
          cur = exp_q.pop_front();
          chk("drdy_cyc", cyc, cur.cyc);
          cap_cnt  = 24;
          cap_word = '0;
        end
      end
    end
  end

  initial begin
    #(10 * 12000);
    fails++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $fatal(1);
  end

  logic [23:0] w [1:9];
  int unsigned ek [1:13];
  int unsigned rel, s_cyc, ey, rel2;
  logic [23:0] ybits;

  initial begin
    cyc = 0; tests = 0; fails = 0; quiet = 1'b0;
    cap_cnt = 0; idx_pending = 1'b0; cap_word = '0;
    rst_dclk = 1'b1; sync_tog = 1'b0; sample_in = '0; sample_valid = 1'b0;
    w[1] = 24'hA5F00F; w[2] = 24'h123456; w[3] = 24'hFFFFFF;
    w[4] = 24'h000001; w[5] = 24'h800000; w[6] = 24'h55AA33;
    w[7] = 24'hC0FFEE; w[8] = 24'h0F0F0F; w[9] = 24'h987654;

    go_to(2);
    chk("rst_drdy", {31'h0, drdy}, 32'h0);
    chk("rst_dout", {31'h0, dout}, 32'h0);
    chk("rst_idx", {29'h0, frame_idx}, 32'h0);
    chk("rst_settling", {31'h0, settling}, 32'h1);
    chk("rst_underrun", {31'h0, underrun}, 32'h0);
    chk("rst_overrun", {31'h0, overrun}, 32'h0);

    go_to(3);
    rst_dclk = 1'b0;
    rel = cyc;
    for (int k = 1; k <= 13; k++) ek[k] = rel + 896 + 128 * (k - 1);

    // Nine consecutive loaded frames; idx after frame k is k mod 8.
    exp_q.push_back('{ek[1], w[1], 3'd1});
    load(w[1]);
    go_to(ek[1] - 1);
    chk("settling_before_first", {31'h0, settling}, 32'h1);
    go_to(ek[1]);
    chk("settling_after_first", {31'h0, settling}, 32'h0);
    for (int k = 2; k <= 9; k++) begin
      go_to(ek[k-1] + 40);
      exp_q.push_back('{ek[k], w[k], 3'(k % 8)});
      load(w[k]);
    end
    go_to(ek[9] + 30);
    chk("no_underrun", {31'h0, underrun}, 32'h0);
    chk("no_overrun", {31'h0, overrun}, 32'h0);

    // Underrun: nothing loaded during period 9, frame 10 repeats w[9].
    exp_q.push_back('{ek[10], w[9], 3'd2});
    go_to(ek[10] + 2);
    chk("underrun_set", {31'h0, underrun}, 32'h1);
    go_to(ek[10] + 40);
    exp_q.push_back('{ek[11], 24'h3C3C3C, 3'd3});
    load(24'h3C3C3C);
    go_to(ek[11] + 5);
    chk("underrun_sticky", {31'h0, underrun}, 32'h1);

    // Overrun: two loads in one period, the second word goes out.
    go_to(ek[11] + 40);
    load(24'h111111);
    chk("overrun_single_load", {31'h0, overrun}, 32'h0);
    go_to(ek[11] + 60);
    exp_q.push_back('{ek[12], 24'hDEAD42, 3'd4});
    load(24'hDEAD42);
    go_to(ek[11] + 62);
    chk("overrun_set", {31'h0, overrun}, 32'h1);

    // Sync toggle at dclk 10 of frame 13 aborts it.
    go_to(ek[12] + 40);
    exp_q.push_back('{ek[13], 24'h6B6B6B, 3'd5});
    load(24'h6B6B6B);
    go_to(ek[13] + 10);
    quiet = 1'b1;
    sync_tog = 1'b1;
    s_cyc = ek[13] + 13;
    go_to(s_cyc);
    chk("sync_dout", {31'h0, dout}, 32'h0);
    chk("sync_drdy", {31'h0, drdy}, 32'h0);
    chk("sync_idx", {29'h0, frame_idx}, 32'h0);
    chk("sync_settling", {31'h0, settling}, 32'h1);
    chk("sync_underrun_clr", {31'h0, underrun}, 32'h0);
    chk("sync_overrun_clr", {31'h0, overrun}, 32'h0);
    go_to(s_cyc + 1);
    quiet = 1'b0;

    // First frame after sync lands 896 dclks after the synchronised edge.
    ybits = 24'h5AF0C3;
    ey = s_cyc + 896;
    go_to(s_cyc + 5);
    exp_q.push_back('{ey, ybits, 3'd1});
    load(ybits);

    // Reset during bit 12 of that frame: outputs drop without a clock edge.
    go_to(ey + 12);
    quiet = 1'b1;
    chk("bit12_before_reset", {31'h0, dout}, {31'h0, ybits[12]});
    rst_dclk = 1'b1;
    sync_tog = 1'b0;
    #1;
    chk("async_rst_dout", {31'h0, dout}, 32'h0);
    chk("async_rst_drdy", {31'h0, drdy}, 32'h0);
    chk("async_rst_settling", {31'h0, settling}, 32'h1);
    go_to(ey + 15);
    rst_dclk = 1'b0;
    rel2 = cyc;
    go_to(rel2 + 1);
    quiet = 1'b0;
    go_to(rel2 + 400);
    chk("post_reset_settling", {31'h0, settling}, 32'h1);
    chk("scoreboard_empty", exp_q.size(), 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
